// File: rtl/otter_mem_pkg.sv
// rtl/otter_mem_pkg.sv - shared encodings, FSM states, cache geometry and load/store helpers
package otter_mem_pkg;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h1100_0000;

  localparam int DC_LINES = 16;
  localparam int DC_WORDS = 4;
  localparam int DC_TAG_W = 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } mem_size_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_HIT_CHK, ST_IO, ST_ERRS, ST_FILL, ST_WRITE, ST_DONE
  } dstate_t;

  function automatic logic misaligned(input mem_size_t size, input logic [1:0] off);
    return (size == SZ_ILL) || (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'd0);
  endfunction

  function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [1:0] off,
                                           input mem_size_t size, input logic zext);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (size)
      SZ_BYTE: return zext ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_HALF: return zext ? {16'b0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  // Merge store data into the old word; only the addressed lanes change.
  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] din,
                                              input logic [1:0] off, input mem_size_t size);
    logic [31:0] r;
    r = old;
    case (size)
      SZ_BYTE: r[{off, 3'b000} +: 8] = din[7:0];
      SZ_HALF: if (off[1]) r[31:16] = din[15:0]; else r[15:0] = din[15:0];
      default: r = din;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/otter_dcache.sv
// rtl/otter_dcache.sv - direct-mapped data cache: 16 lines x 4 words, tag/data/valid arrays and hit logic
module otter_dcache
  import otter_mem_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [15:2]              i_addr,
  input  logic                     i_fill,
  input  logic [DC_WORDS*32-1:0]   i_fill_line,
  input  logic                     i_wr,
  input  logic [31:0]              i_wr_word,
  output logic                     o_hit,
  output logic [31:0]              o_rdata
);

  logic [DC_TAG_W-1:0] r_tag  [DC_LINES];
  logic [31:0]         r_data [DC_LINES][DC_WORDS];
  logic [DC_LINES-1:0] r_valid;

  logic [3:0]          w_idx;
  logic [1:0]          w_off;
  logic [DC_TAG_W-1:0] w_tag;

  assign w_idx   = i_addr[7:4];
  assign w_off   = i_addr[3:2];
  assign w_tag   = i_addr[15:8];
  assign o_hit   = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign o_rdata = r_data[w_idx][w_off];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_valid <= '0;
    else if (i_fill) r_valid[w_idx] <= 1'b1;
  end

  // Write-through keeps memory authoritative, so a store only touches a line that already hits.
  always_ff @(posedge i_clk) begin
    if (i_fill) begin
      r_tag[w_idx] <= w_tag;
      for (int k = 0; k < DC_WORDS; k++) r_data[w_idx][k] <= i_fill_line[32*k +: 32];
    end else if (i_wr && o_hit) begin
      r_data[w_idx][w_off] <= i_wr_word;
    end
  end

endmodule

// File: rtl/otter_memory.sv
// rtl/otter_memory.sv - OTTER instruction/data memory with IO region; data cache built when OTTER_DCACHE_EN is defined
module otter_memory
  import otter_mem_pkg::*;
#(
  parameter int          MISS_LATENCY = 4,
  parameter int          MEM_WORDS    = 16384,
  parameter logic [31:0] IO_BASE      = IO_BASE_DEFAULT
) (
  input  logic        MEM_CLK,
  input  logic        MEM_RST,
  input  logic        MEM_RDEN1,
  input  logic [13:0] MEM_ADDR1,
  output logic [31:0] MEM_DOUT1,
  output logic        MEM_VALID1,
  input  logic        MEM_RDEN2,
  input  logic        MEM_WE2,
  input  logic [31:0] MEM_ADDR2,
  input  logic [31:0] MEM_DIN2,
  input  logic [1:0]  MEM_SIZE,
  input  logic        MEM_SIGN,
  input  logic [31:0] IO_IN,
  output logic        IO_WR,
  output logic [31:0] MEM_DOUT2,
  output logic        MEM_VALID2,
  output logic        ERR
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0] r_mem [MEM_WORDS];
  dstate_t     r_state, w_next;
  logic [7:0]  r_cnt;

  mem_size_t   w_size;
  logic [1:0]  w_off;
  logic [AW-1:0] w_widx;
  logic        w_req, w_is_io, w_bad, w_last;
  logic [31:0] w_mem_word, w_st_word;
  logic        w_valid2_nxt, w_err_nxt, w_iowr_nxt, w_mem_we;
  logic [31:0] w_dout2_nxt;

  assign w_size     = mem_size_t'(MEM_SIZE);
  assign w_off      = MEM_ADDR2[1:0];
  assign w_widx     = MEM_ADDR2[AW+1:2];
  assign w_req      = MEM_WE2 | MEM_RDEN2;
  assign w_is_io    = MEM_ADDR2 >= IO_BASE;
  assign w_bad      = misaligned(w_size, w_off) || (!w_is_io && MEM_ADDR2 >= 32'(MEM_WORDS * 4));
  assign w_last     = r_cnt == 8'(MISS_LATENCY - 1);
  assign w_mem_word = r_mem[w_widx];
  assign w_st_word  = store_merge(w_mem_word, MEM_DIN2, w_off, w_size);

`ifdef OTTER_DCACHE_EN
  logic                   w_hit, w_fill, w_cwr;
  logic [31:0]            w_c_rdata;
  logic [DC_WORDS*32-1:0] w_line;

  always_comb begin
    w_line = '0;
    for (int k = 0; k < DC_WORDS; k++) w_line[32*k +: 32] = r_mem[{w_widx[AW-1:2], 2'(k)}];
  end

  assign w_fill = (r_state == ST_FILL) && w_last;
  assign w_cwr  = (r_state == ST_WRITE) && w_last;

  otter_dcache u_dcache (
    .i_clk       (MEM_CLK),
    .i_rst       (MEM_RST),
    .i_addr      (MEM_ADDR2[15:2]),
    .i_fill      (w_fill),
    .i_fill_line (w_line),
    .i_wr        (w_cwr),
    .i_wr_word   (w_st_word),
    .o_hit       (w_hit),
    .o_rdata     (w_c_rdata)
  );
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_req) w_next = w_bad ? ST_ERRS : (w_is_io ? ST_IO : ST_HIT_CHK);
`ifdef OTTER_DCACHE_EN
      ST_HIT_CHK: w_next = MEM_WE2 ? ST_WRITE : (w_hit ? ST_DONE : ST_FILL);
`else
      ST_HIT_CHK: w_next = ST_DONE;
`endif
      ST_FILL, ST_WRITE: if (w_last) w_next = ST_DONE;
      ST_IO, ST_ERRS:    w_next = ST_DONE;
      default:           w_next = ST_IDLE;
    endcase
  end

  // Next values of the registered completion outputs; memory commits on the completion edge.
  always_comb begin
    w_valid2_nxt = 1'b0;
    w_err_nxt    = 1'b0;
    w_iowr_nxt   = 1'b0;
    w_mem_we     = 1'b0;
    w_dout2_nxt  = MEM_DOUT2;
    case (r_state)
      ST_ERRS: w_err_nxt = 1'b1;
      ST_IO: begin
        w_valid2_nxt = 1'b1;
        if (MEM_WE2) w_iowr_nxt = 1'b1;
        else w_dout2_nxt = load_fmt(IO_IN, w_off, w_size, MEM_SIGN);
      end
`ifdef OTTER_DCACHE_EN
      ST_HIT_CHK: if (!MEM_WE2 && w_hit) begin
        w_valid2_nxt = 1'b1;
        w_dout2_nxt  = load_fmt(w_c_rdata, w_off, w_size, MEM_SIGN);
      end
`else
      ST_HIT_CHK: begin
        w_valid2_nxt = 1'b1;
        if (MEM_WE2) w_mem_we = 1'b1;
        else w_dout2_nxt = load_fmt(w_mem_word, w_off, w_size, MEM_SIGN);
      end
`endif
      ST_FILL: if (w_last) begin
        w_valid2_nxt = 1'b1;
        w_dout2_nxt  = load_fmt(w_mem_word, w_off, w_size, MEM_SIGN);
      end
      ST_WRITE: if (w_last) begin
        w_valid2_nxt = 1'b1;
        w_mem_we     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge MEM_CLK or posedge MEM_RST) begin
    if (MEM_RST) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      MEM_VALID2 <= 1'b0;
      ERR        <= 1'b0;
      IO_WR      <= 1'b0;
      MEM_DOUT2  <= '0;
      MEM_VALID1 <= 1'b0;
      MEM_DOUT1  <= '0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= (w_next == r_state) ? r_cnt + 8'd1 : 8'd0;
      MEM_VALID2 <= w_valid2_nxt;
      ERR        <= w_err_nxt;
      IO_WR      <= w_iowr_nxt;
      MEM_DOUT2  <= w_dout2_nxt;
      MEM_VALID1 <= MEM_RDEN1;
      if (MEM_RDEN1) MEM_DOUT1 <= r_mem[MEM_ADDR1];
    end
  end

  always_ff @(posedge MEM_CLK) begin
    if (w_mem_we) r_mem[w_widx] <= w_st_word;
  end

endmodule

// File: tb/tb_otter_memory.sv
// tb/tb_otter_memory.sv - directed scoreboard bench for otter_memory; latencies follow OTTER_DCACHE_EN
module tb_otter_memory;

  localparam int ML = 4;
`ifdef OTTER_DCACHE_EN
  localparam int MISS = ML + 1;
  localparam int WLAT = ML + 1;
`else
  localparam int MISS = 1;
  localparam int WLAT = 1;
`endif
  localparam int HIT = 1;

  logic        MEM_CLK, MEM_RST, MEM_RDEN1, MEM_VALID1, MEM_RDEN2, MEM_WE2;
  logic [13:0] MEM_ADDR1;
  logic [31:0] MEM_DOUT1, MEM_ADDR2, MEM_DIN2, IO_IN, MEM_DOUT2;
  logic [1:0]  MEM_SIZE;
  logic        MEM_SIGN, IO_WR, MEM_VALID2, ERR;

  typedef struct packed {
    logic        chk;
    logic [31:0] data;
    logic [7:0]  lat;
    logic        err;
    logic        io;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  otter_memory #(.MISS_LATENCY(ML)) dut (
    .MEM_CLK(MEM_CLK), .MEM_RST(MEM_RST),
    .MEM_RDEN1(MEM_RDEN1), .MEM_ADDR1(MEM_ADDR1), .MEM_DOUT1(MEM_DOUT1), .MEM_VALID1(MEM_VALID1),
    .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2), .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2),
    .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN), .IO_IN(IO_IN), .IO_WR(IO_WR),
    .MEM_DOUT2(MEM_DOUT2), .MEM_VALID2(MEM_VALID2), .ERR(ERR)
  );

  initial MEM_CLK = 1'b0;
  always #5 MEM_CLK = ~MEM_CLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge with the data port idle.
  task automatic acc(input string tag, input logic we, input logic [31:0] addr, input logic [31:0] din,
                     input logic [1:0] size, input logic sign, input logic [31:0] io_in,
                     input logic chkd, input logic [31:0] ed, input int elat,
                     input logic eerr, input logic eio);
    exp_t e;
    int   n;
    logic got;
    e.chk = chkd; e.data = ed; e.lat = 8'(elat); e.err = eerr; e.io = eio;
    sb.push_back(e);
    MEM_WE2 = we; MEM_RDEN2 = !we; MEM_ADDR2 = addr; MEM_DIN2 = din;
    MEM_SIZE = size; MEM_SIGN = sign; IO_IN = io_in;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(posedge MEM_CLK); #1;
      n++;
      got = MEM_VALID2 | ERR;
    end
    MEM_WE2 = 1'b0; MEM_RDEN2 = 1'b0;
    e = sb.pop_front();
    chk({tag, "_done"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, "_lat"}, 32'(n - 1), 32'(e.lat));
      chk({tag, "_err"}, 32'(ERR), 32'(e.err));
      chk({tag, "_valid"}, 32'(MEM_VALID2), 32'(!e.err));
      chk({tag, "_iowr"}, 32'(IO_WR), 32'(e.io));
      if (e.chk) chk({tag, "_data"}, MEM_DOUT2, e.data);
    end
    @(posedge MEM_CLK); #1;
    chk({tag, "_pulse_end"}, {29'b0, MEM_VALID2, ERR, IO_WR}, 32'd0);
  endtask

  initial begin
    MEM_RST = 1'b1; MEM_RDEN1 = 1'b0; MEM_ADDR1 = '0; MEM_RDEN2 = 1'b0; MEM_WE2 = 1'b0;
    MEM_ADDR2 = '0; MEM_DIN2 = '0; MEM_SIZE = 2'd2; MEM_SIGN = 1'b1; IO_IN = '0;
    repeat (2) @(posedge MEM_CLK);
    #1;
    chk("rst_outs", {MEM_DOUT1, MEM_DOUT2}  == 64'd0 ? 32'd0 : 32'd1, 32'd0);
    chk("rst_flags", {28'b0, MEM_VALID1, MEM_VALID2, ERR, IO_WR}, 32'd0);
    MEM_RST = 1'b0;

    acc("st_w100",  1, 32'h0100, 32'hDEAD_BEEF, 2'd2, 1, 0, 0, 32'h0,         WLAT, 0, 0);
    acc("ld_w100a", 0, 32'h0100, 32'h0,         2'd2, 1, 0, 1, 32'hDEAD_BEEF, MISS, 0, 0);
    acc("ld_w100b", 0, 32'h0100, 32'h0,         2'd2, 1, 0, 1, 32'hDEAD_BEEF, HIT,  0, 0);

    MEM_RDEN1 = 1'b1; MEM_ADDR1 = 14'h0040;
    @(posedge MEM_CLK); #1;
    chk("if_data", MEM_DOUT1, 32'hDEAD_BEEF);
    chk("if_valid", 32'(MEM_VALID1), 32'd1);
    MEM_RDEN1 = 1'b0; MEM_ADDR1 = 14'h0000;
    @(posedge MEM_CLK); #1;
    chk("if_idle_valid", 32'(MEM_VALID1), 32'd0);
    chk("if_hold", MEM_DOUT1, 32'hDEAD_BEEF);

    acc("st_h202",  1, 32'h0202, 32'h5555_8001, 2'd1, 1, 0, 0, 32'h0,         WLAT, 0, 0);
    acc("ld_h202u", 0, 32'h0202, 32'h0,         2'd1, 1, 0, 1, 32'h0000_8001, MISS, 0, 0);
    acc("ld_h202s", 0, 32'h0202, 32'h0,         2'd1, 0, 0, 1, 32'hFFFF_8001, HIT,  0, 0);
    acc("ld_w200",  0, 32'h0200, 32'h0,         2'd2, 1, 0, 1, 32'h8001_0000, HIT,  0, 0);

    acc("ld_w300a", 0, 32'h0300, 32'h0,         2'd2, 1, 0, 1, 32'h0000_0000, MISS, 0, 0);
    acc("st_b303",  1, 32'h0303, 32'hAAAA_AA80, 2'd0, 1, 0, 0, 32'h0,         WLAT, 0, 0);
    acc("ld_b303s", 0, 32'h0303, 32'h0,         2'd0, 0, 0, 1, 32'hFFFF_FF80, HIT,  0, 0);
    acc("ld_w300b", 0, 32'h0300, 32'h0,         2'd2, 1, 0, 1, 32'h8000_0000, HIT,  0, 0);

    acc("err_w102", 1, 32'h0102, 32'hFFFF_FFFF, 2'd2, 1, 0, 0, 32'h0,         1,    1, 0);
    acc("ld_w100c", 0, 32'h0100, 32'h0,         2'd2, 1, 0, 1, 32'hDEAD_BEEF, MISS, 0, 0);
    acc("err_sz3",  0, 32'h0100, 32'h0,         2'd3, 1, 0, 0, 32'h0,         1,    1, 0);
    acc("err_h101", 0, 32'h0101, 32'h0,         2'd1, 1, 0, 0, 32'h0,         1,    1, 0);
    acc("err_gap",  0, 32'h0001_0000, 32'h0,    2'd2, 1, 0, 0, 32'h0,         1,    1, 0);
    acc("ld_w100d", 0, 32'h0100, 32'h0,         2'd2, 1, 0, 1, 32'hDEAD_BEEF, HIT,  0, 0);

    acc("io_st",    1, 32'h1100_0000, 32'h1234_5678, 2'd2, 1, 32'h0,         0, 32'h0,         1, 0, 1);
    acc("io_ld",    0, 32'h1100_0000, 32'h0,         2'd2, 1, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, 1, 0, 0);
    acc("io_ldb",   0, 32'h1100_0001, 32'h0,         2'd0, 0, 32'hCAFE_F00D, 1, 32'hFFFF_FFF0, 1, 0, 0);

    // Reset in the middle of a miss on a line conflicting with the cached 0x100.
    MEM_RDEN1 = 1'b1; MEM_ADDR1 = 14'h0040;
    @(posedge MEM_CLK); #1;
    MEM_RDEN1 = 1'b0;
    MEM_RDEN2 = 1'b1; MEM_ADDR2 = 32'h0400; MEM_SIZE = 2'd2; MEM_SIGN = 1'b1;
    @(posedge MEM_CLK);
`ifdef OTTER_DCACHE_EN
    @(posedge MEM_CLK);
`endif
    #1;
    MEM_RST = 1'b1; MEM_RDEN2 = 1'b0;
    #1;
    chk("rstmid_dout2", MEM_DOUT2, 32'h0);
    chk("rstmid_dout1", MEM_DOUT1, 32'h0);
    chk("rstmid_flags", {28'b0, MEM_VALID1, MEM_VALID2, ERR, IO_WR}, 32'd0);
    @(posedge MEM_CLK); #1;
    MEM_RST = 1'b0;
    acc("ld_post_rst",  0, 32'h0100, 32'h0, 2'd2, 1, 0, 1, 32'hDEAD_BEEF, MISS, 0, 0);
    acc("ld_post_rst2", 0, 32'h0100, 32'h0, 2'd2, 1, 0, 1, 32'hDEAD_BEEF, HIT,  0, 0);

    // A store cut off by reset must not reach memory.
    MEM_WE2 = 1'b1; MEM_ADDR2 = 32'h0100; MEM_DIN2 = 32'h1111_1111; MEM_SIZE = 2'd2;
    @(posedge MEM_CLK); #1;
    MEM_RST = 1'b1; MEM_WE2 = 1'b0;
    #1;
    chk("rstst_valid", 32'(MEM_VALID2), 32'd0);
    @(posedge MEM_CLK); #1;
    MEM_RST = 1'b0;
    acc("ld_after_abort", 0, 32'h0100, 32'h0, 2'd2, 1, 0, 1, 32'hDEAD_BEEF, MISS, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/otter_memory.md
OTTER_MEMORY -- requirements
Module: otter_memory

Interface
REQ-001 SHALL have parameter MISS_LATENCY, default 4: backing-memory cycles per cache fill or write-through.
REQ-002 SHALL have parameter MEM_WORDS, default 16384: backing memory size in 32-bit words (64 KiB, byte addresses 0x0000-0xFFFF).
REQ-003 SHALL have parameter IO_BASE, default 32'h1100_0000: first byte address of the uncached IO region.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, with these ports (name, direction, width, meaning):
- MEM_CLK, in, 1: clock, rising edge.
- MEM_RST, in, 1: asynchronous active-high reset.
- MEM_RDEN1, in, 1: instruction read enable.
- MEM_ADDR1, in, 14: instruction word address.
- MEM_DOUT1, out, 32: instruction word.
- MEM_VALID1, out, 1: instruction data valid.
- MEM_RDEN2, in, 1: data read request.
- MEM_WE2, in, 1: data write request.
- MEM_ADDR2, in, 32: data byte address.
- MEM_DIN2, in, 32: store data, also the IO output data.
- MEM_SIZE, in, 2: access size; 0=byte, 1=half, 2=word, 3=illegal.
- MEM_SIGN, in, 1: load extension; 1=zero-extend, 0=sign-extend.
- IO_IN, in, 32: IO read data.
- IO_WR, out, 1: one-cycle IO write strobe.
- MEM_DOUT2, out, 32: load result.
- MEM_VALID2, out, 1: data access complete.
- ERR, out, 1: data access rejected.

Function
REQ-005 Instruction port: if MEM_RDEN1 is sampled high at an edge, MEM_DOUT1 SHALL receive mem[MEM_ADDR1] and MEM_VALID1 SHALL be 1 in the following cycle; otherwise MEM_VALID1 SHALL be 0 and MEM_DOUT1 SHALL hold its value.
REQ-006 Data port SHALL accept a request in IDLE when MEM_RDEN2 or MEM_WE2 is high; MEM_WE2 has priority. The requester holds all inputs stable until it sees VALID2 or ERR.
REQ-007 Completion SHALL be a registered one-cycle pulse on MEM_VALID2 or ERR (never both); no new request SHALL be accepted during the pulse cycle.
REQ-008 ERR SHALL pulse 1 cycle after acceptance, with no state change, for any of: MEM_SIZE=3; half access at an odd address; word access with addr[1:0]≠0; address ≥ MEM_WORDS*4 and < IO_BASE.
REQ-009 Data cache: direct-mapped, 16 lines of 4 words; tag=addr[15:8], index=addr[7:4], word offset=addr[3:2]; one valid bit per line.
REQ-010 Load hit SHALL pulse VALID2 1 cycle after acceptance; a load miss SHALL fill the whole line from backing memory and pulse VALID2 MISS_LATENCY+1 cycles after acceptance.
REQ-011 Stores SHALL be write-through, no-write-allocate; they SHALL update only the addressed bytes in memory, and also in the cache line on a hit; VALID2 SHALL pulse MISS_LATENCY+1 cycles after acceptance; the memory write SHALL commit in the completion cycle.
REQ-012 Store byte lanes: byte writes DIN2[7:0] at addr[1:0]; half writes DIN2[15:0] at addr[1]*2; word writes all 4 bytes.
REQ-013 Load formatting: select the byte or half by the low address bits, right-align it, and extend per MEM_SIGN; MEM_DOUT2 SHALL update on the completion edge and hold until the next completion.
REQ-014 IO region (addr ≥ IO_BASE), uncached, 1-cycle latency: a store SHALL pulse IO_WR together with VALID2; a load SHALL return IO_IN formatted per REQ-013.
REQ-015 Data FSM states SHALL be IDLE→(HIT_CHK | IO | ERRS)→FILL/WRITE (MISS_LATENCY cycles)→DONE→IDLE.

Reset
REQ-016 Reset SHALL asynchronously force all outputs to 0, clear all cache valid bits and set the FSM to IDLE; an in-flight miss or store SHALL be aborted without a memory write.
REQ-017 Backing memory SHALL not be reset; it SHALL initialize to zero at time 0.

Configuration
REQ-018 With OTTER_DCACHE_EN defined, the cache SHALL be built per REQ-009–011; without it, every in-range access SHALL go directly to memory with VALID2 pulsing 1 cycle after acceptance, and the behaviour at the ports SHALL otherwise be identical.

Structure
REQ-019 Package otter_mem_pkg SHALL hold the size encodings, the FSM state enum, the cache geometry constants and the IO_BASE default.
REQ-020 The cache tag/data/valid arrays and hit logic SHALL be in sub-module otter_dcache.

Verification
REQ-021 Word store 0xDEADBEEF to 0x0100, then unsigned word load from 0x0100 -> 0xDEADBEEF; first load is a miss (VALID2 after MISS_LATENCY+1 cycles), a repeat load hits in 1 cycle.
REQ-022 Half store 0x8001 to 0x0202, then load -> 0x00008001 with SIGN=1 and 0xFFFF8001 with SIGN=0; the other half of the word is unchanged.
REQ-023 Byte store 0x80 to 0x0303, then signed byte load -> 0xFFFFFF80; word load of 0x0300 -> only byte 3 changed.
REQ-024 Word access at 0x0102, or MEM_SIZE=3 -> ERR pulse, no VALID2, memory unchanged.
REQ-025 Store 0x12345678 to 0x1100_0000 -> IO_WR and VALID2 pulse together; load from the same address with IO_IN=0xCAFEF00D -> 0xCAFEF00D.
REQ-026 Assert MEM_RST mid-miss -> outputs go to 0 immediately, and a subsequent load of a previously cached address misses.
